// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_pkg
// Purpose  : Shared definitions for the spiking front end. Holds the SRAM
//            geometry, the spike encoder state encoding and the words that
//            the encoder writes into the spike frame.
// Contents : ADDR_W, DATA_W, enc_state_t, SPIKE_WORD, NOSPIKE_WORD
// Revision : 1.0 - initial release
// ============================================================================
package snn_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ENC_IDLE  = 2'd0,
    ENC_RUN   = 2'd1,
    ENC_DRAIN = 2'd2,
    ENC_DONE  = 2'd3
  } enc_state_t;

  localparam logic [15:0] SPIKE_WORD   = 16'd1;
  localparam logic [15:0] NOSPIKE_WORD = 16'd0;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit Galois LFSR used as a pseudo-random threshold source.
//            Steps once per cycle in which advance is high; reloads SEED on
//            reset. SEED must be nonzero or the register locks at zero.
// Ports    : clk     - system clock
//            reset   - synchronous, active-high; loads SEED
//            advance - step the register this cycle
//            q       - current LFSR value
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] q
);

  // Galois form: shift right, fold the feedback mask in when bit 0 drops out.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (advance) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_encoder
// Purpose  : Rate-coding input stage. On start, streams row_size*col_size
//            pixels from a pixel RAM, compares each 8-bit intensity against
//            the low byte of a free-running LFSR and writes one spike word
//            (1 = spike, 0 = none) per pixel into the spike SRAM. done is
//            level-held while start stays high so it can drive the next
//            stage's start directly.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            start / done         - level request / frame-complete handshake
//            row_size, col_size   - frame geometry (sampled on accept)
//            src_start_address    - pixel frame base (sampled on accept)
//            src_address          - pixel RAM read address (registered)
//            src_readdata         - pixel word, valid one cycle after address
//            dest_start_address   - spike frame base (sampled on accept)
//            dest_address         - spike SRAM write address (registered)
//            dest_writedata       - spike word
//            dest_write_en        - write strobe, one cycle per pixel
//            spike_count          - spikes in the current or last frame
// Revision : 1.0 - initial release
// ============================================================================
module spike_encoder
  import snn_pkg::*;
#(
  parameter int          ADDR_W    = snn_pkg::ADDR_W,
  parameter int          DATA_W    = snn_pkg::DATA_W,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [5:0]        row_size,
  input  logic [5:0]        col_size,
  input  logic [ADDR_W-1:0] src_start_address,
  output logic [ADDR_W-1:0] src_address,
  input  logic [DATA_W-1:0] src_readdata,
  input  logic [ADDR_W-1:0] dest_start_address,
  output logic [ADDR_W-1:0] dest_address,
  output logic [DATA_W-1:0] dest_writedata,
  output logic              dest_write_en,
  output logic [ADDR_W-1:0] spike_count
);

  enc_state_t        state;
  logic [11:0]       n_req;      // requested pixel count, from live inputs
  logic [11:0]       n_frame;    // pixel count latched on accept
  logic [11:0]       rd_idx;     // index of the read address currently issued
  logic [11:0]       wr_idx;     // index of the next pixel to be written
  logic [ADDR_W-1:0] dest_base;
  logic              addr_vld;   // src_address holds a live read this cycle
  logic              data_vld;   // src_readdata holds a live pixel this cycle
  logic [15:0]       lfsr_q;
  logic              spike;
  logic              unused_bits;

  // 6x6-bit product fits in 12 bits (63*63 = 3969).
  assign n_req = {6'd0, row_size} * {6'd0, col_size};

  // Strict compare: pixel 0 can never spike.
  assign spike = src_readdata[7:0] > lfsr_q[7:0];

  assign unused_bits = ^{src_readdata[DATA_W-1:8], lfsr_q[15:8]};

  // The threshold steps exactly once per written pixel, so each pixel sees
  // the LFSR value left behind by the previous one.
  lfsr16 #(
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (data_vld),
    .q       (lfsr_q)
  );

  // Read pipeline: address issued (addr_vld) -> RAM returns the word one
  // cycle later (data_vld) -> compare and register the write. The first
  // write is therefore visible two cycles after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ENC_IDLE;
      done           <= 1'b0;
      src_address    <= '0;
      dest_address   <= '0;
      dest_writedata <= '0;
      dest_write_en  <= 1'b0;
      spike_count    <= '0;
      n_frame        <= '0;
      rd_idx         <= '0;
      wr_idx         <= '0;
      dest_base      <= '0;
      addr_vld       <= 1'b0;
      data_vld       <= 1'b0;
    end else begin
      dest_write_en  <= 1'b0;
      dest_writedata <= DATA_W'(NOSPIKE_WORD);
      data_vld       <= addr_vld;

      if (data_vld) begin
        dest_write_en  <= 1'b1;
        dest_address   <= dest_base + ADDR_W'(wr_idx);
        dest_writedata <= spike ? DATA_W'(SPIKE_WORD) : DATA_W'(NOSPIKE_WORD);
        wr_idx         <= wr_idx + 12'd1;
        if (spike && (spike_count != {ADDR_W{1'b1}})) begin
          spike_count <= spike_count + ADDR_W'(1);
        end
      end

      case (state)
        ENC_IDLE: begin
          done     <= 1'b0;
          addr_vld <= 1'b0;
          if (start) begin
            spike_count <= '0;
            if (n_req != 12'd0) begin
              state       <= ENC_RUN;
              n_frame     <= n_req;
              dest_base   <= dest_start_address;
              src_address <= src_start_address;
              rd_idx      <= 12'd0;
              wr_idx      <= 12'd0;
              addr_vld    <= 1'b1;
            end else begin
              // Empty frame: nothing to stream, report completion at once.
              state <= ENC_DONE;
              done  <= 1'b1;
            end
          end
        end

        ENC_RUN: begin
          if (rd_idx == n_frame - 12'd1) begin
            state    <= ENC_DRAIN;
            addr_vld <= 1'b0;
          end else begin
            src_address <= src_address + ADDR_W'(1);
            rd_idx      <= rd_idx + 12'd1;
            addr_vld    <= 1'b1;
          end
        end

        ENC_DRAIN: begin
          addr_vld <= 1'b0;
          // Pipeline empty means the last write is on the bus now; done
          // rises together with the strobe dropping.
          if (!addr_vld && !data_vld) begin
            state <= ENC_DONE;
            done  <= 1'b1;
          end
        end

        ENC_DONE: begin
          addr_vld <= 1'b0;
          if (!start) begin
            state <= ENC_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state    <= ENC_IDLE;
          done     <= 1'b0;
          addr_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_encoder
// Purpose  : Self-checking bench for spike_encoder. A behavioural model
//            computes the expected spike frame from the pixel memory and a
//            software LFSR; a monitor compares every write cycle against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [5:0]  row_size;
  logic [5:0]  col_size;
  logic [11:0] src_start_address;
  logic [11:0] src_address;
  logic [15:0] src_readdata;
  logic [11:0] dest_start_address;
  logic [11:0] dest_address;
  logic [15:0] dest_writedata;
  logic        dest_write_en;
  logic [11:0] spike_count;

  always #5 clk = ~clk;

  spike_encoder dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .done               (done),
    .row_size           (row_size),
    .col_size           (col_size),
    .src_start_address  (src_start_address),
    .src_address        (src_address),
    .src_readdata       (src_readdata),
    .dest_start_address (dest_start_address),
    .dest_address       (dest_address),
    .dest_writedata     (dest_writedata),
    .dest_write_en      (dest_write_en),
    .spike_count        (spike_count)
  );

  // Pixel RAM: synchronous read, data one cycle after the address.
  logic [15:0] pmem [0:4095];
  always @(posedge clk) src_readdata <= pmem[src_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] model_lfsr;
  logic [11:0] model_count;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // ---------------- monitor ----------------
  int          wr_count = 0;
  int          first_wr_cyc = -1;
  int          last_wr_cyc = -1;
  logic [15:0] act_q[$];
  logic [11:0] src_hist [int];

  always @(negedge clk) begin
    wr_t e;
    src_hist[cyc] = src_address;
    if (dest_write_en === 1'b1) begin
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      act_q.push_back(dest_writedata);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got write addr %0h data %0h, expected no write (cycle %0d)",
                 dest_address, dest_writedata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", dest_address, e.addr);
        chk("wr_data", dest_writedata, e.data);
      end
    end else begin
      chk("idle_data_zero", dest_writedata, 32'd0);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wen"}, dest_write_en, 0);
    chk({tag, "_src_addr"}, src_address, 0);
    chk({tag, "_dest_addr"}, dest_address, 0);
    chk({tag, "_wdata"}, dest_writedata, 0);
    chk({tag, "_spike_count"}, spike_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_lfsr = 16'hACE1;
  endtask

  // fill: 0 = zeros, 1 = all 255, 2 = random, 3 = constant pix, 4 = keep
  task automatic run_frame(input int rows, input int cols,
                           input logic [11:0] sa, input logic [11:0] da,
                           input int fill, input int pix,
                           input bit drop_early, input int abort_at);
    int          n;
    int          a;
    int          base_wr;
    int          done_cyc;
    int          bad;
    logic [11:0] addr;
    logic [7:0]  p;
    wr_t         e;
    n = rows * cols;
    done_cyc = -1;
    for (int k = 0; k < n; k++) begin
      addr = sa + 12'(k);
      case (fill)
        0: pmem[addr] = {8'($urandom), 8'h00};
        1: pmem[addr] = {8'($urandom), 8'hFF};
        2: pmem[addr] = 16'($urandom);
        3: pmem[addr] = {8'($urandom), 8'(pix)};
        default: ;
      endcase
    end
    model_count = 12'd0;
    for (int k = 0; k < n; k++) begin
      p = pmem[sa + 12'(k)][7:0];
      e.addr = da + 12'(k);
      e.data = (p > model_lfsr[7:0]) ? 16'd1 : 16'd0;
      exp_q.push_back(e);
      if (e.data == 16'd1 && model_count != 12'hFFF) model_count++;
      model_lfsr = lfsr_next(model_lfsr);
    end
    act_q.delete();
    first_wr_cyc = -1;
    base_wr = wr_count;
    row_size = 6'(rows);
    col_size = 6'(cols);
    src_start_address = sa;
    dest_start_address = da;
    start = 1'b1;
    a = cyc + 1;
    for (int t = 0; t < n + 30; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        // Inputs are sampled on accept; changing them now must not matter.
        row_size = 6'($urandom);
        col_size = 6'($urandom);
        src_start_address = 12'($urandom);
        dest_start_address = 12'($urandom);
      end
      if (abort_at > 0 && dest_write_en === 1'b1 && (wr_count - base_wr) == abort_at - 1) begin
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals("abort");
        exp_q.delete();
        model_lfsr = 16'hACE1;
        return;
      end
      if (drop_early && cyc <= a + n) start = (cyc == a + n) ? 1'b0 : 1'($urandom);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done, expected done by cycle %0d", a + n + 2);
      start = 1'b0;
      @(posedge clk); #1;
      return;
    end
    chk("done_cycle", done_cyc, (n == 0) ? a : a + n + 2);
    chk("write_count", wr_count - base_wr, n);
    if (n > 0) begin
      chk("first_write_cycle", first_wr_cyc, a + 2);
      chk("last_write_cycle", last_wr_cyc, a + n + 1);
      bad = 0;
      for (int k = 0; k < n; k++)
        if (src_hist[a + k] !== sa + 12'(k)) bad++;
      chk("src_addr_seq_errs", bad, 0);
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("spike_count", spike_count, model_count);
    if (drop_early) begin
      @(posedge clk); #1;
      chk("done_pulse_end", done, 0);
    end else begin
      @(posedge clk); #1;
      chk("done_held", done, 1);
      start = 1'b0;
      @(posedge clk); #1;
      chk("done_clear", done, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] first_bits[$];
    int          bad;
    reset = 1'b1;
    start = 1'b0;
    row_size = 6'd0;
    col_size = 6'd0;
    src_start_address = 12'd0;
    dest_start_address = 12'd0;
    for (int i = 0; i < 4096; i++) pmem[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    model_lfsr = 16'hACE1;

    // Pin the model's LFSR step to a hand-computed value.
    chk("model_lfsr_step", lfsr_next(model_lfsr), 16'hE270);

    // 1x1, pixel 226 vs threshold 0xE1 -> spike.
    run_frame(1, 1, 12'h010, 12'h200, 3, 226, 1'b0, 0);
    chk("t1_data", act_q[0], 16'd1);
    chk("t1_spike_count", spike_count, 12'd1);

    // 1x1, pixel 225 -> no spike; then 226 against advanced threshold 0x70.
    do_reset();
    run_frame(1, 1, 12'h010, 12'h200, 3, 225, 1'b0, 0);
    chk("t2a_data", act_q[0], 16'd0);
    chk("t2a_spike_count", spike_count, 12'd0);
    chk("model_lfsr_lo", model_lfsr[7:0], 8'h70);
    run_frame(1, 1, 12'h010, 12'h200, 3, 226, 1'b0, 0);
    chk("t2b_data", act_q[0], 16'd1);

    // 28x28 all-zero and all-255 frames.
    run_frame(28, 28, 12'h100, 12'h800, 0, 0, 1'b0, 0);
    chk("zero_frame_spikes", spike_count, 12'd0);
    run_frame(28, 28, 12'h100, 12'h800, 1, 0, 1'b0, 0);

    // Empty frames: held start, then start dropped immediately.
    run_frame(0, 5, 12'h000, 12'h000, 2, 0, 1'b0, 0);
    run_frame(5, 0, 12'h000, 12'h000, 2, 0, 1'b1, 0);

    // Address wrap.
    run_frame(2, 2, 12'hFFE, 12'hFFF, 2, 0, 1'b0, 0);

    // Reset at write 10 of a 4x4 frame, then replay from reset.
    do_reset();
    run_frame(4, 4, 12'h300, 12'h400, 2, 0, 1'b0, 10);
    first_bits = act_q;
    chk("abort_write_count", first_bits.size(), 10);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_quiet_wen", dest_write_en, 0);
      chk("abort_quiet_done", done, 0);
    end
    run_frame(4, 4, 12'h300, 12'h400, 4, 0, 1'b0, 0);
    bad = 0;
    for (int k = 0; k < 10; k++)
      if (k >= first_bits.size() || act_q[k] !== first_bits[k]) bad++;
    chk("replay_bit_exact_errs", bad, 0);

    // Randomized frames with random start behaviour.
    for (int i = 0; i < 14; i++) begin
      run_frame($urandom_range(0, 9), $urandom_range(1, 9), 12'($urandom), 12'($urandom),
                2, 0, 1'($urandom), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
